// File: rtl/im_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package im_pkg;

    localparam int IM_DEPTH  = 8192;
    localparam int INSTR_W   = 17;
    localparam int ADDR_W    = 16;
    localparam int LEN_BYTES = 2;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        B2,
        B1,
        B0,
        WRITE,
        FINISH,
        ERROR
    } load_state_t;

endpackage

// File: rtl/im_load_ctrl_rx_timeout.sv
// Idle-cycle watchdog: counts cycles since the last kick while enabled,
// flags expiry once LIMIT idle cycles have elapsed.
module rx_timeout #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en || kick) begin
            cnt <= '0;
        end else if (cnt != CW'(LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = en && (cnt == CW'(LIMIT));

endmodule

// File: rtl/im_load_ctrl.sv
// Instruction-memory port arbiter: passes CPU fetches through when idle and
// loads a length-prefixed program from the byte stream on request.
module im_load_ctrl #(
    parameter int ADDR_W  = im_pkg::ADDR_W,
    parameter int INSTR_W = im_pkg::INSTR_W,
    parameter int DEPTH   = im_pkg::IM_DEPTH,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_req,
    input  logic [7:0]          rx_byte,
    input  logic                rx_vld,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cpu_rd_en,
    output logic [ADDR_W-1:0]   im_addr,
    output logic                im_rd_en,
    output logic                im_we,
    output logic [INSTR_W-1:0]  im_wdata,
    output logic                cpu_stall,
    output logic                busy,
    output logic                load_done,
    output logic                load_err,
    output im_pkg::load_state_t dbg_state
);

    import im_pkg::*;

    localparam int LEN_W = 8 * LEN_BYTES;

    // Byte stream: rx_byte is consumed on any posedge where rx_vld is high and
    // the FSM is waiting for a byte; there is no back-pressure, so bytes that
    // arrive in WRITE, FINISH, ERROR or IDLE are dropped.
    load_state_t       state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [LEN_W-1:0]  word_cnt;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  hdr_len;
    logic              hi_bit;
    logic [7:0]        mid_byte;
    logic              in_rx;
    logic              to_expired;

    assign hdr_len   = {len[LEN_W-1:8], rx_byte};
    assign in_rx     = (state == LEN_HI) || (state == LEN_LO) || (state == B2) ||
                       (state == B1) || (state == B0);
    assign im_addr   = (state == IDLE) ? cpu_addr : wr_ptr;
    assign im_rd_en  = (state == IDLE) && cpu_rd_en;
    assign dbg_state = state;

    rx_timeout #(
        .LIMIT(TIMEOUT)
    ) u_rx_timeout (
        .clk    (clk),
        .rst    (rst),
        .en     (in_rx),
        .kick   (rx_vld),
        .expired(to_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            word_cnt  <= '0;
            len       <= '0;
            hi_bit    <= 1'b0;
            mid_byte  <= '0;
            im_we     <= 1'b0;
            im_wdata  <= '0;
            cpu_stall <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            im_we     <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            // A byte landing on the expiry cycle still counts as on time.
            if (in_rx && !rx_vld && to_expired) begin
                state     <= ERROR;
                load_err  <= 1'b1;
                cpu_stall <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_req) begin
                            state     <= LEN_HI;
                            wr_ptr    <= '0;
                            word_cnt  <= '0;
                            cpu_stall <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    LEN_HI: begin
                        if (rx_vld) begin
                            len[LEN_W-1:8] <= rx_byte;
                            state          <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (rx_vld) begin
                            len <= hdr_len;
                            if (hdr_len == '0) begin
                                state     <= FINISH;
                                load_done <= 1'b1;
                                cpu_stall <= 1'b0;
                                busy      <= 1'b0;
                            end else if (int'(hdr_len) > DEPTH) begin
                                state     <= ERROR;
                                load_err  <= 1'b1;
                                cpu_stall <= 1'b0;
                                busy      <= 1'b0;
                            end else begin
                                state <= B2;
                            end
                        end
                    end
                    B2: begin
                        if (rx_vld) begin
                            if (rx_byte[7:1] != 7'd0) begin
                                state     <= ERROR;
                                load_err  <= 1'b1;
                                cpu_stall <= 1'b0;
                                busy      <= 1'b0;
                            end else begin
                                hi_bit <= rx_byte[0];
                                state  <= B1;
                            end
                        end
                    end
                    B1: begin
                        if (rx_vld) begin
                            mid_byte <= rx_byte;
                            state    <= B0;
                        end
                    end
                    B0: begin
                        if (rx_vld) begin
                            im_wdata <= INSTR_W'({hi_bit, mid_byte, rx_byte});
                            im_we    <= 1'b1;
                            state    <= WRITE;
                        end
                    end
                    WRITE: begin
                        wr_ptr   <= wr_ptr + ADDR_W'(1);
                        word_cnt <= word_cnt + LEN_W'(1);
                        if ((word_cnt + LEN_W'(1)) == len) begin
                            state     <= FINISH;
                            load_done <= 1'b1;
                            cpu_stall <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            state <= B2;
                        end
                    end
                    FINISH:  state <= IDLE;
                    ERROR:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_load_ctrl.sv
// Randomised scoreboard bench for im_load_ctrl: a byte-stream parser model
// predicts memory writes and done/error pulses, a monitor compares them.
module tb_im_load_ctrl;

    import im_pkg::*;

    localparam int TO = 64;
    localparam int EW = 35;

    logic               clk;
    logic               rst;
    logic               load_req;
    logic [7:0]         rx_byte;
    logic               rx_vld;
    logic [15:0]        cpu_addr;
    logic               cpu_rd_en;
    logic [15:0]        im_addr;
    logic               im_rd_en;
    logic               im_we;
    logic [16:0]        im_wdata;
    logic               cpu_stall;
    logic               busy;
    logic               load_done;
    logic               load_err;
    load_state_t        dbg_state;

    logic [EW-1:0] exp_q[$];
    int checks;
    int errors;

    im_load_ctrl #(
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .rx_byte  (rx_byte),
        .rx_vld   (rx_vld),
        .cpu_addr (cpu_addr),
        .cpu_rd_en(cpu_rd_en),
        .im_addr  (im_addr),
        .im_rd_en (im_rd_en),
        .im_we    (im_we),
        .im_wdata (im_wdata),
        .cpu_stall(cpu_stall),
        .busy     (busy),
        .load_done(load_done),
        .load_err (load_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] ev(input logic [1:0] kind, input logic [15:0] addr,
                                         input logic [16:0] data);
        return {kind, addr, data};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: parse the stream as header + 3-byte words.
    // kind 1 = write, 2 = load_done, 3 = load_err.
    task automatic model_load(input logic [7:0] b[$], input bit stall_end);
        int n;
        int p;
        if (b.size() < 2) begin
            if (stall_end) exp_q.push_back(ev(2'd3, 16'd0, 17'd0));
            return;
        end
        n = {b[0], b[1]};
        p = 2;
        if (n == 0) begin
            exp_q.push_back(ev(2'd2, 16'd0, 17'd0));
            return;
        end
        if (n > IM_DEPTH) begin
            exp_q.push_back(ev(2'd3, 16'd0, 17'd0));
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (p < b.size() && b[p] > 8'd1) begin
                exp_q.push_back(ev(2'd3, 16'd0, 17'd0));
                return;
            end
            if (p + 3 > b.size()) begin
                if (stall_end) exp_q.push_back(ev(2'd3, 16'd0, 17'd0));
                return;
            end
            exp_q.push_back(ev(2'd1, 16'(w), {b[p][0], b[p+1], b[p+2]}));
            p += 3;
        end
        exp_q.push_back(ev(2'd2, 16'd0, 17'd0));
    endtask

    // ---------------- driver tasks ----------------
    // Returns one step after the edge that sampled the byte.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_byte = b;
        rx_vld  = 1'b1;
        @(posedge clk);
        #1;
        rx_vld  = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] b[$]);
        foreach (b[i]) begin
            send_byte(b[i]);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
    endtask

    task automatic pulse_load_req();
        cpu_rd_en = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        @(negedge clk);
        check("stall_rise", {cpu_stall, busy, im_rd_en}, 3'b110);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic run_load(input logic [7:0] b[$], input bit stall_end, input int budget);
        model_load(b, stall_end);
        pulse_load_req();
        send_stream(b);
        drain(budget);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] act;
        forever begin
            @(negedge clk);
            if (!rst && (im_we || load_done || load_err)) begin
                if (im_we)          act = ev(2'd1, im_addr, im_wdata);
                else if (load_done) act = ev(2'd2, 16'd0, 17'd0);
                else                act = ev(2'd3, 16'd0, 17'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual=%h required=none", act);
                end else begin
                    check("event", act, exp_q.pop_front());
                end
                if (load_done || load_err)
                    check("stall_release", {cpu_stall, busy}, 2'b00);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b[$];
        logic [16:0] data;
        int n;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        load_req  = 1'b0;
        rx_byte   = 8'h00;
        rx_vld    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_rd_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {im_we, im_wdata, cpu_stall, busy, load_done, load_err}, '0);
        #1;
        rst = 1'b0;

        // pass-through
        cpu_addr  = 16'h0042;
        cpu_rd_en = 1'b1;
        @(negedge clk);
        check("pass_addr", im_addr, 16'h0042);
        check("pass_ctrl", {im_rd_en, im_we, cpu_stall}, 3'b100);

        // two-word load with write-latency check
        b = '{8'h00, 8'h02, 8'h01, 8'hAB, 8'hCD, 8'h00, 8'h12, 8'h34};
        model_load(b, 1'b0);
        pulse_load_req();
        foreach (b[i]) begin
            send_byte(b[i]);
            if (i == 4 || i == 7) begin
                @(negedge clk);
                check("write_latency", {im_we, im_addr}, {1'b1, 16'((i - 4) / 3)});
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain(50);

        // bad headers
        b = '{8'h20, 8'h01};
        run_load(b, 1'b0, 50);
        b = '{8'h00, 8'h00};
        run_load(b, 1'b0, 50);

        // bad top byte; trailing bytes must be dropped
        b = '{8'h00, 8'h01, 8'h02, 8'h11, 8'h22};
        run_load(b, 1'b0, 50);

        // timeout after the length header
        b = '{8'h00, 8'h01};
        run_load(b, 1'b1, TO + 100);

        // load_req in the middle of a load is ignored
        b = '{8'h00, 8'h02, 8'h00, 8'h55, 8'hAA, 8'h01, 8'hFF, 8'h00};
        model_load(b, 1'b0);
        pulse_load_req();
        foreach (b[i]) begin
            send_byte(b[i]);
            if (i == 3) begin
                @(posedge clk);
                #1;
                load_req = 1'b1;
                @(posedge clk);
                #1;
                load_req = 1'b0;
            end
        end
        drain(50);

        // random loads, idle junk bytes and pass-through
        for (int t = 0; t < 12; t++) begin
            repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 255)));
            cpu_addr  = 16'($urandom_range(0, 65535));
            cpu_rd_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("pass_rand", {im_addr, im_rd_en}, {cpu_addr, cpu_rd_en});
            n = $urandom_range(1, 5);
            b = '{};
            b.push_back(8'(n >> 8));
            b.push_back(8'(n));
            for (int w = 0; w < n; w++) begin
                data = 17'($urandom);
                if ($urandom_range(0, 7) == 0) b.push_back(8'($urandom_range(2, 255)));
                else                           b.push_back({7'd0, data[16]});
                b.push_back(data[15:8]);
                b.push_back(data[7:0]);
            end
            run_load(b, 1'b0, 100);
        end

        // reset mid-load: maximum legal length, one word written, then reset after B1
        b = '{8'h20, 8'h00, 8'h00, 8'h12, 8'h34, 8'h01, 8'h56};
        model_load(b, 1'b0);
        pulse_load_req();
        send_stream(b);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_load", {im_we, im_wdata, cpu_stall, busy, load_done, load_err}, '0);
        check("reset_pass", {im_addr, im_rd_en}, {cpu_addr, cpu_rd_en});
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        check("reset_no_pulse", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
